// File: rtl/nyan_keys_pkg.sv
// ---------------------------------------------------------------------------
// nyan_keys_pkg
// Shared constants for the key front end: default key count, system clock,
// debounce sample period and the derived prescaler divide ratio.
// No ports; imported by keys_debounce and key_debounce_cell.
// ---------------------------------------------------------------------------
package nyan_keys_pkg;

  localparam int NUM_KEYS_DEFAULT  = 61;
  localparam int SYS_CLK_HZ        = 92_000_000;
  localparam int DEBOUNCE_TICK_US  = 100;

  // clk cycles per sample tick: 92 cycles/us * 100 us = 9200
  localparam int SAMPLE_DIV_DEFAULT = (SYS_CLK_HZ / 1_000_000) * DEBOUNCE_TICK_US;

  // Switches are active-low, so an idle (released) key reads 1.
  localparam logic KEY_RELEASED = 1'b1;

endpackage : nyan_keys_pkg

// File: rtl/key_debounce_cell.sv
// ---------------------------------------------------------------------------
// key_debounce_cell
// One key: two-flop synchroniser, saturating-free integrator counter and the
// stable (debounced) output flop.
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   tick     : one-cycle sample strobe shared by all cells
//   key_i    : raw asynchronous switch input (0 = pressed)
//   key_o    : debounced, registered key state
//   flip_o   : combinational; high in the cycle key_o is about to change
// ---------------------------------------------------------------------------
module key_debounce_cell
  import nyan_keys_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 5
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick,
  input  logic key_i,
  output logic key_o,
  output logic flip_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             flip_d;
  logic             ks;

  assign ks = sync_q[1];

  always_comb begin
    // NOTE: every comb output gets a default first so no path can hold a
    // previous value, which is what would otherwise infer a latch.
    sync_d   = {sync_q[0], key_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_d   = 1'b0;
    if (tick) begin
      if (ks == stable_q) begin
        // Any agreeing sample restarts the count.
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = ks;
        cnt_d    = '0;
        flip_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= {2{KEY_RELEASED}};
      cnt_q    <= '0;
      stable_q <= KEY_RELEASED;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; the
      // synchroniser chain depends on this to stay two stages deep.
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign key_o  = stable_q;
  assign flip_o = flip_d;

endmodule : key_debounce_cell

// File: rtl/keys_debounce.sv
// ---------------------------------------------------------------------------
// keys_debounce
// Debounces NUM_KEYS active-low switches for the SPI key-report stage.
// Owns the sample prescaler, instantiates one key_debounce_cell per key and
// merges their flip strobes into a single registered change pulse.
//   clk_i          : system clock
//   rst_n_i        : asynchronous active-low reset
//   keys_i         : raw switch inputs, asynchronous, 0 = pressed
//   keys_o         : debounced key vector, registered
//   keys_changed_o : one-cycle pulse, coincident with a new keys_o value
//   sample_tick_o  : one-cycle pulse per sample tick (debug / alignment)
// ---------------------------------------------------------------------------
module keys_debounce
  import nyan_keys_pkg::*;
#(
  parameter int NUM_KEYS     = NUM_KEYS_DEFAULT,
  parameter int SAMPLE_DIV   = SAMPLE_DIV_DEFAULT,
  parameter int DEBOUNCE_CNT = 5
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                keys_changed_o,
  output logic                sample_tick_o
);

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  logic                sample_tick_q, sample_tick_d;
  logic                changed_q, changed_d;
  logic [NUM_KEYS-1:0] flip;

  // The cells act on the comb decode; the registered copy on sample_tick_o
  // therefore lines up with the cycle in which their updates become visible.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    sample_tick_d = tick;
    changed_d     = |flip;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q         <= '0;
      sample_tick_q <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      sample_tick_q <= sample_tick_d;
      changed_q     <= changed_d;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .tick    (tick),
      .key_i   (keys_i[k]),
      .key_o   (keys_o[k]),
      .flip_o  (flip[k])
    );
  end

  assign keys_changed_o = changed_q;
  assign sample_tick_o  = sample_tick_q;

endmodule : keys_debounce
